// File: rtl/pc_unit.sv
// Program counter with sequential advance, branch/call redirect and a circular
// return-address stack; one action per cycle with stall > call > branch > ret > advance.
module pc_unit #(
  parameter int unsigned PC_W      = 5,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  localparam int unsigned AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [PC_W-1:0] StepW  = PC_W'(STEP);
  localparam logic [PC_W-1:0] RstVec = PC_W'(RESET_VEC);
  localparam logic [CW-1:0]   DepthC = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    ActHold,
    ActCall,
    ActBranch,
    ActRet,
    ActUnderflow,
    ActAdvance
  } act_e;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            err_q, err_d;
  logic [PC_W-1:0] stack_q [RAS_DEPTH];

  act_e            act;
  logic            push;
  logic            full;
  logic [PC_W-1:0] seq_pc;
  logic [AW-1:0]   top_idx;

  assign full    = (cnt_q == DepthC);
  assign seq_pc  = pc_q + StepW;
  // ptr_q is the next free slot; the newest entry sits one below it (mod depth).
  assign top_idx = ptr_q - AW'(1);

  always_comb begin
    act = ActAdvance;
    if (stall) begin
      act = ActHold;
    end else if (call) begin
      act = ActCall;
    end else if (branch) begin
      act = ActBranch;
    end else if (ret) begin
      act = (cnt_q == '0) ? ActUnderflow : ActRet;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    err_d = err_q;
    push  = 1'b0;
    case (act)
      ActHold: ;
      ActCall: begin
        push  = 1'b1;
        pc_d  = target;
        ptr_d = ptr_q + AW'(1);
        // When full the write slot is the oldest entry, so it is overwritten in place.
        if (full) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ActBranch: pc_d = target;
      ActRet: begin
        pc_d  = stack_q[top_idx];
        ptr_d = top_idx;
        cnt_d = cnt_q - CW'(1);
      end
      ActUnderflow: begin
        pc_d  = seq_pc;
        err_d = 1'b1;
      end
      default: pc_d = seq_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RstVec;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  // Entry storage is not reset; cnt_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      stack_q[ptr_q] <= seq_pc;
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = valid_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = full;
  assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: queue-based reference model compared every cycle,
// plus directed sequences with hand-computed expectations.
module tb_pc_unit;

  localparam int PcW   = 5;
  localparam int Depth = 4;
  localparam int Mod   = 1 << PcW;

  logic           clk = 1'b0;
  logic           rst;
  logic           stall, branch, call, ret;
  logic [PcW-1:0] target;
  logic [PcW-1:0] pc;
  logic           pc_valid, ras_empty, ras_full, ras_err;

  pc_unit dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .branch   (branch),
    .call     (call),
    .ret      (ret),
    .target   (target),
    .pc       (pc),
    .pc_valid (pc_valid),
    .ras_empty(ras_empty),
    .ras_full (ras_full),
    .ras_err  (ras_err)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers and a queue for the stack (back = top).
  int m_pc;
  int m_valid;
  int m_err;
  int stk[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_pc = 0; m_valid = 0; m_err = 0;
      stk.delete();
    end else begin
      m_valid = 1;
      if (stall) begin
      end else if (call) begin
        if (stk.size() == Depth) begin
          void'(stk.pop_front());
          m_err = 1;
        end
        stk.push_back((m_pc + 1) % Mod);
        m_pc = int'(target);
      end else if (branch) begin
        m_pc = int'(target);
      end else if (ret) begin
        if (stk.size() > 0) m_pc = stk.pop_back();
        else begin
          m_pc  = (m_pc + 1) % Mod;
          m_err = 1;
        end
      end else begin
        m_pc = (m_pc + 1) % Mod;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    if (chk_en) begin
      check("model.pc", int'(pc), m_pc);
      check("model.pc_valid", int'(pc_valid), m_valid);
      check("model.ras_empty", int'(ras_empty), int'(stk.size() == 0));
      check("model.ras_full", int'(ras_full), int'(stk.size() == Depth));
      check("model.ras_err", int'(ras_err), m_err);
    end
  endtask

  // Drive one cycle of inputs, then sample after the edge and compare with the model.
  task automatic cyc(input logic r, input logic s, input logic b, input logic c,
                     input logic t, input logic [PcW-1:0] tg);
    rst = r; stall = s; branch = b; call = c; ret = t; target = tg;
    @(negedge clk);
    chk_en = 1'b1;
    model_cmp();
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), PcW'($urandom));
    check("reset.pc", int'(pc), 0);
    check("reset.valid", int'(pc_valid), 0);
    check("reset.empty", int'(ras_empty), 1);
    check("reset.err", int'(ras_err), 0);
  endtask

  task automatic go(input logic s, input logic b, input logic c, input logic t,
                    input logic [PcW-1:0] tg);
    cyc(1'b1, s, b, c, t, tg);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0; target = '0;
    @(negedge clk);
    do_reset();

    // Free-running count with wrap; valid rises after the first post-reset cycle.
    for (int i = 1; i <= 40; i++) begin
      go(0, 0, 0, 0, 0);
      check("free.pc", int'(pc), i % 32);
      check("free.valid", int'(pc_valid), 1);
    end

    // Branch, and stall overriding branch.
    do_reset();
    go(0, 1, 0, 0, 5);
    go(1, 1, 0, 0, 20);
    check("stall.pc", int'(pc), 5);
    check("stall.valid", int'(pc_valid), 1);
    go(0, 1, 0, 0, 20);
    check("branch.pc", int'(pc), 20);

    // Nested call/ret.
    do_reset();
    go(0, 1, 0, 0, 3);
    go(0, 0, 1, 0, 10);
    check("call1.pc", int'(pc), 10);
    go(0, 1, 0, 0, 12);
    go(0, 0, 1, 0, 25);
    check("call2.pc", int'(pc), 25);
    go(0, 0, 0, 1, 0);
    check("ret1.pc", int'(pc), 13);
    go(0, 0, 0, 1, 0);
    check("ret2.pc", int'(pc), 4);
    check("ret2.empty", int'(ras_empty), 1);
    check("ret2.err", int'(ras_err), 0);

    // Overflow: fifth call overwrites the oldest return address (1).
    do_reset();
    go(0, 0, 1, 0, 10);
    go(0, 0, 1, 0, 20);
    go(0, 0, 1, 0, 30);
    go(0, 0, 1, 0, 5);
    check("ovf4.full", int'(ras_full), 1);
    check("ovf4.err", int'(ras_err), 0);
    go(0, 0, 1, 0, 15);
    check("ovf5.full", int'(ras_full), 1);
    check("ovf5.err", int'(ras_err), 1);
    go(0, 0, 0, 1, 0); check("ovf.ret1", int'(pc), 6);
    go(0, 0, 0, 1, 0); check("ovf.ret2", int'(pc), 31);
    go(0, 0, 0, 1, 0); check("ovf.ret3", int'(pc), 21);
    go(0, 0, 0, 1, 0); check("ovf.ret4", int'(pc), 11);
    check("ovf.empty", int'(ras_empty), 1);
    go(0, 0, 0, 1, 0); check("ovf.ret5", int'(pc), 12);

    // Underflow sets a sticky error.
    do_reset();
    go(0, 1, 0, 0, 7);
    go(0, 0, 0, 1, 0);
    check("unf.pc", int'(pc), 8);
    check("unf.err", int'(ras_err), 1);
    for (int i = 0; i < 5; i++) go(0, 1, 1, 0, PcW'(i));
    check("unf.sticky", int'(ras_err), 1);
    do_reset();
    check("unf.cleared", int'(ras_err), 0);

    // All requests at once: call wins, single push of 3.
    go(0, 1, 0, 0, 2);
    go(0, 1, 1, 1, 9);
    check("prio.pc", int'(pc), 9);
    check("prio.empty", int'(ras_empty), 0);
    go(0, 0, 0, 1, 0);
    check("prio.ret", int'(pc), 3);
    check("prio.empty2", int'(ras_empty), 1);
    go(0, 1, 0, 0, 2);
    go(0, 1, 1, 1, 9);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd17);
    check("midrst.pc", int'(pc), 0);
    check("midrst.empty", int'(ras_empty), 1);
    check("midrst.err", int'(ras_err), 0);
    check("midrst.valid", int'(pc_valid), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), PcW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
